// File: rtl/axi_mem_slave.sv
// AXI4 slave front-end for a single-port synchronous word memory (SRAM, or ROM
// when READ_ONLY=1). Each accepted burst becomes one memory access per beat.
module axi_mem_slave #(
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ID_W      = 8,
   parameter int unsigned LEN_W     = 4,
   parameter int unsigned READ_ONLY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   // read address channel
   input  logic [ID_W-1:0]       arid,
   input  logic [31:0]           araddr,
   input  logic [LEN_W-1:0]      arlen,
   input  logic [1:0]            arburst,
   input  logic                  arvalid,
   output logic                  arready,
   // read data channel
   output logic [ID_W-1:0]       rid,
   output logic [DATA_W-1:0]     rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   // write address channel
   input  logic [ID_W-1:0]       awid,
   input  logic [31:0]           awaddr,
   input  logic [LEN_W-1:0]      awlen,
   input  logic [1:0]            awburst,
   input  logic                  awvalid,
   output logic                  awready,
   // write data channel
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   // write response channel
   output logic [ID_W-1:0]       bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   // memory port
   output logic                  mem_en,
   output logic [DATA_W/8-1:0]   mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_din,
   input  logic [DATA_W-1:0]     mem_dout
);

   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RADDR,
      S_RDATA,
      S_WDATA,
      S_WRESP
   } state_t;

   typedef enum logic {
      PRI_RD,
      PRI_WR
   } pri_t;

   state_t              r_state,  w_state_nxt;
   pri_t                r_pri,    w_pri_nxt;
   logic [ID_W-1:0]     r_id,     w_id_nxt;
   logic [ADDR_W-1:0]   r_cur,    w_cur_nxt;
   logic [LEN_W-1:0]    r_len,    w_len_nxt;
   logic [LEN_W-1:0]    r_cnt,    w_cnt_nxt;
   logic [1:0]          r_burst,  w_burst_nxt;
   logic                r_err,    w_err_nxt;

   logic [ADDR_W-1:0]   w_cur_inc;
   logic [ADDR_W-1:0]   w_cur_step;
   logic [ADDR_W-1:0]   w_wrap_mask;
   logic                w_last_beat;
   logic                w_wr_blocked;
   logic                w_unused_addr;

   // Illegal burst: reserved encoding, or WRAP whose beat count is not a power of two >= 2.
   function automatic logic f_bad_burst(input logic [1:0] burst, input logic [LEN_W-1:0] len);
      logic wrap_ok;
      wrap_ok = (len != '0) && ((len & (len + LEN_W'(1))) == '0);
      return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_ok);
   endfunction

   // Illegal bursts still walk memory, as INCR.
   function automatic logic [1:0] f_eff_burst(input logic [1:0] burst, input logic [LEN_W-1:0] len);
      return f_bad_burst(burst, len) ? BURST_INCR : burst;
   endfunction

   assign w_unused_addr = ^{araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};

   assign w_last_beat  = (r_cnt == r_len);
   assign w_wr_blocked = r_err || (READ_ONLY != 0);

   // Next beat address; WRAP keeps the upper bits and wraps the low log2(len+1) bits.
   always_comb begin
      w_wrap_mask = ADDR_W'(r_len);
      w_cur_inc   = r_cur + ADDR_W'(1);
      case (r_burst)
         BURST_FIXED: w_cur_step = r_cur;
         BURST_WRAP:  w_cur_step = (r_cur & ~w_wrap_mask) | (w_cur_inc & w_wrap_mask);
         default:     w_cur_step = w_cur_inc;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pri_nxt   = r_pri;
      w_id_nxt    = r_id;
      w_cur_nxt   = r_cur;
      w_len_nxt   = r_len;
      w_cnt_nxt   = r_cnt;
      w_burst_nxt = r_burst;
      w_err_nxt   = r_err;
      arready     = 1'b0;
      awready     = 1'b0;
      rvalid      = 1'b0;
      wready      = 1'b0;
      bvalid      = 1'b0;
      mem_en      = 1'b0;
      mem_we      = '0;

      case (r_state)
         S_IDLE: begin
            arready = rst && (!awvalid || (r_pri == PRI_RD));
            awready = rst && (!arvalid || (r_pri == PRI_WR));
            if (arvalid && arready) begin
               w_id_nxt    = arid;
               w_cur_nxt   = araddr[ADDR_W+1:2];
               w_len_nxt   = arlen;
               w_burst_nxt = f_eff_burst(arburst, arlen);
               w_err_nxt   = f_bad_burst(arburst, arlen);
               w_cnt_nxt   = '0;
               w_pri_nxt   = PRI_WR;
               w_state_nxt = S_RADDR;
            end else if (awvalid && awready) begin
               w_id_nxt    = awid;
               w_cur_nxt   = awaddr[ADDR_W+1:2];
               w_len_nxt   = awlen;
               w_burst_nxt = f_eff_burst(awburst, awlen);
               w_err_nxt   = f_bad_burst(awburst, awlen) || (READ_ONLY != 0);
               w_cnt_nxt   = '0;
               w_pri_nxt   = PRI_RD;
               w_state_nxt = S_WDATA;
            end
         end

         S_RADDR: begin
            mem_en      = 1'b1;
            w_state_nxt = S_RDATA;
         end

         S_RDATA: begin
            rvalid = 1'b1;
            if (rready) begin
               if (w_last_beat) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt   = r_cnt + LEN_W'(1);
                  w_cur_nxt   = w_cur_step;
                  w_state_nxt = S_RADDR;
               end
            end
         end

         S_WDATA: begin
            wready = 1'b1;
            if (wvalid) begin
               mem_en    = 1'b1;
               mem_we    = w_wr_blocked ? STRB_W'(0) : wstrb;
               w_cnt_nxt = r_cnt + LEN_W'(1);
               w_cur_nxt = w_cur_step;
               // Burst ends on whichever of wlast / final count comes first.
               if (wlast || w_last_beat) begin
                  w_state_nxt = S_WRESP;
               end
               if (wlast != w_last_beat) begin
                  w_err_nxt = 1'b1;
               end
            end
         end

         S_WRESP: begin
            bvalid = 1'b1;
            if (bready) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_pri   <= PRI_RD;
         r_id    <= '0;
         r_cur   <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_burst <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pri   <= w_pri_nxt;
         r_id    <= w_id_nxt;
         r_cur   <= w_cur_nxt;
         r_len   <= w_len_nxt;
         r_cnt   <= w_cnt_nxt;
         r_burst <= w_burst_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign rid      = r_id;
   assign rdata    = mem_dout;
   assign rlast    = (r_state == S_RDATA) && w_last_beat;
   assign rresp    = r_err ? RESP_SLVERR : RESP_OKAY;
   assign bid      = r_id;
   assign bresp    = r_err ? RESP_SLVERR : RESP_OKAY;
   assign mem_addr = r_cur;
   assign mem_din  = wdata;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: a read/write instance with a memory model
// and a READ_ONLY instance driven in lockstep from the same channel inputs.
module tb_axi_mem_slave;

   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;
   localparam logic [1:0] RSVD  = 2'b11;
   localparam logic [1:0] OK    = 2'b00;
   localparam logic [1:0] SLV   = 2'b10;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rexp_t;

   typedef struct packed {
      logic [13:0] addr;
      logic [3:0]  we;
      logic [31:0] din;
   } wexp_t;

   typedef struct packed {
      logic [7:0] id;
      logic [1:0] resp;
   } bexp_t;

   logic        clk, rst;
   logic [7:0]  arid, awid;
   logic [31:0] araddr, awaddr;
   logic [3:0]  arlen, awlen;
   logic [1:0]  arburst, awburst;
   logic        arvalid, awvalid, rready, bready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid;

   logic        arready, awready, rvalid, rlast, wready, bvalid, mem_en;
   logic [7:0]  rid, bid;
   logic [31:0] rdata, mem_din, mem_dout;
   logic [1:0]  rresp, bresp;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;

   logic        ro_arready, ro_awready, ro_rvalid, ro_rlast, ro_wready, ro_bvalid, ro_mem_en;
   logic [7:0]  ro_rid, ro_bid;
   logic [31:0] ro_rdata, ro_mem_din;
   logic [1:0]  ro_rresp, ro_bresp;
   logic [3:0]  ro_mem_we;
   logic [13:0] ro_mem_addr;
   logic        ro_unused_sink;

   logic [31:0] mem [0:16383];

   rexp_t       rq[$];
   logic [13:0] maq[$];
   wexp_t       wq[$];
   bexp_t       bq[$];
   logic [7:0]  roq[$];
   logic        gq[$];

   int n_checks = 0;
   int n_pass   = 0;
   int rr_mode  = 0;
   int cyc      = 0;
   int ar_cyc   = 0;
   logic lat_pend = 1'b0;

   axi_mem_slave #(.ADDR_W(14), .DATA_W(32), .ID_W(8), .LEN_W(4), .READ_ONLY(0)) dut (
      .clk(clk), .rst(rst),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   axi_mem_slave #(.ADDR_W(14), .DATA_W(32), .ID_W(8), .LEN_W(4), .READ_ONLY(1)) dut_ro (
      .clk(clk), .rst(rst),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(ro_arready),
      .rid(ro_rid), .rdata(ro_rdata), .rresp(ro_rresp), .rlast(ro_rlast), .rvalid(ro_rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(ro_awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(ro_wready),
      .bid(ro_bid), .bresp(ro_bresp), .bvalid(ro_bvalid), .bready(bready),
      .mem_en(ro_mem_en), .mem_we(ro_mem_we), .mem_addr(ro_mem_addr), .mem_din(ro_mem_din), .mem_dout(32'h0)
   );

   assign ro_unused_sink = ^{ro_arready, ro_awready, ro_rvalid, ro_rlast, ro_rid, ro_rdata,
                             ro_rresp, ro_mem_addr, ro_mem_din, ro_mem_en};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: word i initialised to 0xD000_0000 + i.
   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'hD000_0000 + i;
      mem_dout = '0;
   end

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we == 4'b0000) begin
            mem_dout <= mem[mem_addr];
         end else begin
            for (int b = 0; b < 4; b++)
               if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic flag(input string nm);
      n_checks++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   task automatic exp_beat(input logic [7:0] id, input logic [13:0] w, input logic [31:0] d,
                           input logic [1:0] resp, input logic last);
      rq.push_back('{id: id, data: d, resp: resp, last: last});
      maq.push_back(w);
   endtask

   task automatic rd(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len, input logic [1:0] bt);
      int n;
      @(negedge clk);
      arid = id; araddr = a; arlen = len; arburst = bt; arvalid = 1'b1;
      #1;
      n = 0;
      while (!arready && n < 200) begin @(negedge clk); #1; n++; end
      if (!arready) flag("ar_timeout");
      @(posedge clk);
      #1 arvalid = 1'b0;
   endtask

   task automatic wr(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len, input logic [1:0] bt);
      int n;
      @(negedge clk);
      awid = id; awaddr = a; awlen = len; awburst = bt; awvalid = 1'b1;
      #1;
      n = 0;
      while (!awready && n < 200) begin @(negedge clk); #1; n++; end
      if (!awready) flag("aw_timeout");
      @(posedge clk);
      #1 awvalid = 1'b0;
   endtask

   task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n;
      @(negedge clk);
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      #1;
      n = 0;
      while (!wready && n < 200) begin @(negedge clk); #1; n++; end
      if (!wready) flag("w_timeout");
      @(posedge clk);
      #1 begin wvalid = 1'b0; wlast = 1'b0; end
   endtask

   task automatic wait_rvalid();
      int n;
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
      if (!rvalid) flag("rvalid_timeout");
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rq.size() + maq.size() + wq.size() + bq.size() + roq.size()) != 0 && n < 300) begin
         @(negedge clk); n++;
      end
      if (n >= 300) flag("drain_timeout");
      repeat (2) @(negedge clk);
   endtask

   // rready pattern: 0 = held high, 1 = toggling, other = driven by stimulus.
   initial begin
      forever begin
         @(negedge clk);
         if (rr_mode == 1) rready = ~rready;
      end
   end

   // Monitor: samples mid-low-phase, pops and compares on every DUT event.
   initial begin
      logic ar_hs, aw_hs;
      forever begin
         @(negedge clk); #3;
         cyc++;
         if (rst) begin
            ar_hs = arvalid && arready;
            aw_hs = awvalid && awready;
            if (arvalid && awvalid) chk("one_ready", 64'(arready && awready), 64'(0));
            if ((ar_hs || aw_hs) && gq.size() > 0) chk("grant_order", 64'(aw_hs), 64'(gq.pop_front()));
            if (lat_pend && rvalid) begin
               chk("ar_to_rvalid", 64'(cyc - ar_cyc), 64'(2));
               lat_pend = 1'b0;
            end
            if (ar_hs) begin lat_pend = 1'b1; ar_cyc = cyc; end
            if (mem_en && !wready) begin
               if (maq.size() == 0) flag("unexpected_mem_read");
               else chk("rd_addr", 64'(mem_addr), 64'(maq.pop_front()));
            end
            if (rvalid) begin
               if (rq.size() == 0) flag("unexpected_rbeat");
               else if (rready) chk("r_beat", 64'({rid, rdata, rresp, rlast}), 64'(rq.pop_front()));
               else chk("rdata_hold", 64'({rid, rdata, rresp, rlast}), 64'(rq[0]));
            end
            if (wvalid && wready) begin
               if (wq.size() == 0) flag("unexpected_wbeat");
               else chk("w_beat", 64'({mem_en, mem_addr, mem_we, mem_din}), 64'({1'b1, wq.pop_front()}));
            end
            if (wvalid && ro_wready) chk("ro_mem_we", 64'(ro_mem_we), 64'(0));
            if (bvalid && bready) begin
               if (bq.size() == 0) flag("unexpected_b");
               else chk("b_resp", 64'({bid, bresp}), 64'(bq.pop_front()));
            end
            if (ro_bvalid && bready) begin
               if (roq.size() == 0) flag("unexpected_ro_b");
               else chk("ro_b_resp", 64'({ro_bid, ro_bresp}), 64'({roq.pop_front(), SLV}));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      rready = 1'b1; bready = 1'b1;

      // Arbitration from reset: single read, strobed write, then read-back of the write.
      exp_beat(8'h11, 14'd4, 32'hD000_0004, OK, 1'b1);
      wq.push_back('{addr: 14'd2, we: 4'b0011, din: 32'h1111_2222});
      wq.push_back('{addr: 14'd3, we: 4'b1100, din: 32'h3333_4444});
      bq.push_back('{id: 8'h22, resp: OK});
      roq.push_back(8'h22);
      exp_beat(8'h33, 14'd2, 32'hD000_2222, OK, 1'b0);
      exp_beat(8'h33, 14'd3, 32'h3333_0003, OK, 1'b1);
      gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0);
      fork
         begin
            rd(8'h11, 32'h10, 4'd0, INCR);
            rd(8'h33, 32'h08, 4'd1, INCR);
         end
         begin
            wr(8'h22, 32'h08, 4'd1, INCR);
            wbeat(32'h1111_2222, 4'b0011, 1'b0);
            wbeat(32'h3333_4444, 4'b1100, 1'b1);
         end
         begin
            repeat (3) @(negedge clk);
            #2;
            chk("rst_arready", 64'(arready), 64'(0));
            chk("rst_awready", 64'(awready), 64'(0));
            chk("rst_idle_outs", 64'({rvalid, bvalid, wready, mem_en, mem_we}), 64'(0));
            @(negedge clk);
            rst = 1'b1;
         end
      join
      drain();
      chk("grant_queue_empty", 64'(gq.size()), 64'(0));

      // INCR len=3 with rready toggling; word 3 carries the earlier partial write.
      rr_mode = 1;
      exp_beat(8'h44, 14'd3, 32'h3333_0003, OK, 1'b0);
      exp_beat(8'h44, 14'd4, 32'hD000_0004, OK, 1'b0);
      exp_beat(8'h44, 14'd5, 32'hD000_0005, OK, 1'b0);
      exp_beat(8'h44, 14'd6, 32'hD000_0006, OK, 1'b1);
      rd(8'h44, 32'h0C, 4'd3, INCR);
      drain();
      rr_mode = 0;
      rready = 1'b1;

      // WRAP len=3 from word 6: 6,7,4,5.
      exp_beat(8'h45, 14'd6, 32'hD000_0006, OK, 1'b0);
      exp_beat(8'h45, 14'd7, 32'hD000_0007, OK, 1'b0);
      exp_beat(8'h45, 14'd4, 32'hD000_0004, OK, 1'b0);
      exp_beat(8'h45, 14'd5, 32'hD000_0005, OK, 1'b1);
      rd(8'h45, 32'h18, 4'd3, WRAP);
      drain();

      // WRAP len=2 is illegal: SLVERR on every beat, addresses advance as INCR.
      exp_beat(8'h46, 14'd6, 32'hD000_0006, SLV, 1'b0);
      exp_beat(8'h46, 14'd7, 32'hD000_0007, SLV, 1'b0);
      exp_beat(8'h46, 14'd8, 32'hD000_0008, SLV, 1'b1);
      rd(8'h46, 32'h18, 4'd2, WRAP);
      drain();

      // FIXED len=2 stays on word 5.
      exp_beat(8'h47, 14'd5, 32'hD000_0005, OK, 1'b0);
      exp_beat(8'h47, 14'd5, 32'hD000_0005, OK, 1'b0);
      exp_beat(8'h47, 14'd5, 32'hD000_0005, OK, 1'b1);
      rd(8'h47, 32'h14, 4'd2, FIXED);
      drain();

      // Reserved burst type: SLVERR, reads as INCR.
      exp_beat(8'h48, 14'd1, 32'hD000_0001, SLV, 1'b0);
      exp_beat(8'h48, 14'd2, 32'hD000_2222, SLV, 1'b1);
      rd(8'h48, 32'h04, 4'd1, RSVD);
      drain();

      // INCR wraps from the top word to word 0; address bits [1:0] ignored.
      exp_beat(8'h49, 14'h3FFF, 32'hD000_3FFF, OK, 1'b0);
      exp_beat(8'h49, 14'h0000, 32'hD000_0000, OK, 1'b1);
      rd(8'h49, 32'h0000_FFFF, 4'd1, INCR);
      drain();

      // Reset during beat 2 of a len=7 read: abort, no further response.
      rr_mode = 2;
      rready = 1'b0;
      exp_beat(8'h55, 14'd16, 32'hD000_0010, OK, 1'b0);
      exp_beat(8'h55, 14'd17, 32'hD000_0011, OK, 1'b0);
      rd(8'h55, 32'h40, 4'd7, INCR);
      wait_rvalid();
      rready = 1'b1;
      @(posedge clk);
      #1 rready = 1'b0;
      wait_rvalid();
      rst = 1'b0;
      arvalid = 1'b1; araddr = 32'h20; arid = 8'h66; arlen = 4'd2; arburst = INCR;
      #3;
      chk("midrst_rvalid", 64'(rvalid), 64'(0));
      chk("midrst_arready", 64'(arready), 64'(0));
      chk("midrst_mem_en", 64'(mem_en), 64'(0));
      rq.delete();
      maq.delete();
      lat_pend = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("postrst_arready", 64'(arready), 64'(1));
      arvalid = 1'b0;
      rr_mode = 0;
      rready = 1'b1;
      exp_beat(8'h66, 14'd8,  32'hD000_0008, OK, 1'b0);
      exp_beat(8'h66, 14'd9,  32'hD000_0009, OK, 1'b0);
      exp_beat(8'h66, 14'd10, 32'hD000_000A, OK, 1'b1);
      rd(8'h66, 32'h20, 4'd2, INCR);
      drain();

      chk("rq_empty", 64'(rq.size()), 64'(0));
      chk("bq_empty", 64'(bq.size() + roq.size() + wq.size() + maq.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
